// File: rtl/ccff_loader_pkg.sv
// ccff_loader_pkg: shared types and constants for the configuration-chain
// loader and its CRC helper.
//   ld_state_e : loader FSM states (IDLE, LOAD, DONE)
//   CRC_POLY   : CRC-16-CCITT polynomial (non-reflected)
//   CRC_INIT   : CRC seed loaded at the start of every load
//   ceil_div   : number of WORD_W words needed to cover CHAIN_LEN bits
package ccff_loader_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    DONE = 2'd2
  } ld_state_e;

  localparam logic [15:0] CRC_POLY = 16'h1021;
  localparam logic [15:0] CRC_INIT = 16'hFFFF;

  function automatic int ceil_div(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

endpackage

// File: rtl/ccff_crc16_serial.sv
// ccff_crc16_serial: bit-serial CRC-16-CCITT (MSB-first, no reflection,
// no final XOR). Shared by the loader and the readback checker.
//   clk, rst_n : clock, asynchronous active-low reset (crc -> CRC_INIT)
//   clr        : reload CRC_INIT (wins over en)
//   en         : fold bit_in into the CRC on this edge
//   bit_in     : serial data bit
//   crc        : current CRC register
module ccff_crc16_serial
  import ccff_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        en,
  input  logic        bit_in,
  output logic [15:0] crc
);

  logic [15:0] crc_q, crc_d;
  logic        fb;

  always_comb begin
    crc_d = crc_q;
    fb    = crc_q[15] ^ bit_in;
    if (clr)
      crc_d = CRC_INIT;
    else if (en)
      crc_d = {crc_q[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) crc_q <= CRC_INIT;
    else        crc_q <= crc_d;
  end

  assign crc = crc_q;

endmodule

// File: rtl/ccff_bitstream_loader.sv
// ccff_bitstream_loader: serialises configuration words onto a tile column's
// configuration chain (ccff) and CRCs the bits falling out of the chain tail
// so the previous contents can be read back.
//   prog_clk, prog_rst_n : configuration clock, async active-low reset
//   start, abort         : begin a load (IDLE only) / cancel a load (LOAD only)
//   cfg_data/valid/ready : word stream, bit 0 shifted first
//   ccff_head            : serial bit presented to the chain head
//   ccff_shift_en        : chain prog_clk gate enable for this cycle
//   ccff_tail            : bit leaving the chain tail (sampled on shift edges)
//   busy, done, aborted  : load status; done/aborted are one-cycle pulses
//   bit_count            : bits shifted in the current/last load
//   readback_crc         : CRC-16-CCITT over captured tail bits
module ccff_bitstream_loader
  import ccff_loader_pkg::*;
#(
  parameter int CHAIN_LEN = 36,
  parameter int WORD_W    = 8
) (
  input  logic              prog_clk,
  input  logic              prog_rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [WORD_W-1:0] cfg_data,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  output logic              ccff_head,
  output logic              ccff_shift_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [15:0]       bit_count,
  output logic [15:0]       readback_crc
);

  localparam int WORDS     = ceil_div(CHAIN_LEN, WORD_W);
  localparam int WCW       = $clog2(WORDS) + 1;
  localparam int BLW       = $clog2(WORD_W + 1);
  localparam int LAST_BITS = CHAIN_LEN - (WORDS - 1) * WORD_W;

  localparam logic [WCW-1:0] WORDS_C     = WCW'(WORDS);
  localparam logic [WCW-1:0] LAST_WORD_C = WCW'(WORDS - 1);
  localparam logic [BLW-1:0] LAST_BITS_C = BLW'(LAST_BITS);
  localparam logic [BLW-1:0] FULL_BITS_C = BLW'(WORD_W);
  localparam logic [BLW-1:0] ONE_BIT_C   = BLW'(1);
  localparam logic [15:0]    LAST_CNT_C  = 16'(CHAIN_LEN - 1);

  ld_state_e         state_q, state_d;
  logic [WORD_W-1:0] shreg_q, shreg_d;
  logic              shreg_vld_q, shreg_vld_d;
  logic [BLW-1:0]    bits_left_q, bits_left_d;   // used bits left in shreg, incl. bit 0
  logic [WCW-1:0]    word_cnt_q, word_cnt_d;
  logic [15:0]       bit_count_q, bit_count_d;
  logic              ccff_head_q, ccff_head_d;
  logic              ccff_shift_en_q, ccff_shift_en_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              aborted_q, aborted_d;

  logic start_go, shift, accept;

  // Ready when the buffer is empty or is about to give up its last used bit,
  // which lets a new word slide in behind the final shift with no bubble.
  always_comb begin
    cfg_ready = (state_q == LOAD) && (word_cnt_q < WORDS_C) &&
                (!shreg_vld_q || (bits_left_q == ONE_BIT_C));
  end

  always_comb begin
    start_go = (state_q == IDLE) && start;
    // abort wins over both the shift and the word hand-off
    shift    = (state_q == LOAD) && shreg_vld_q && !abort;
    accept   = cfg_ready && cfg_valid && !abort;
  end

  always_comb begin
    state_d     = state_q;
    shreg_d     = shreg_q;
    shreg_vld_d = shreg_vld_q;
    bits_left_d = bits_left_q;
    word_cnt_d  = word_cnt_q;
    bit_count_d = bit_count_q;
    aborted_d   = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d     = LOAD;
          bit_count_d = '0;
          word_cnt_d  = '0;
          shreg_vld_d = 1'b0;
        end
      end
      LOAD: begin
        if (abort) begin
          state_d     = IDLE;
          aborted_d   = 1'b1;
          shreg_vld_d = 1'b0;
        end else begin
          if (shift) begin
            bit_count_d = bit_count_q + 16'd1;
            shreg_d     = shreg_q >> 1;
            bits_left_d = bits_left_q - ONE_BIT_C;
            if (bits_left_q == ONE_BIT_C) shreg_vld_d = 1'b0;
          end
          if (accept) begin
            shreg_d     = cfg_data;
            shreg_vld_d = 1'b1;
            // final word only contributes the bits that still fit the chain
            bits_left_d = (word_cnt_q == LAST_WORD_C) ? LAST_BITS_C : FULL_BITS_C;
            word_cnt_d  = word_cnt_q + 1'b1;
          end
          if (shift && (bit_count_q == LAST_CNT_C)) begin
            state_d     = DONE;
            shreg_vld_d = 1'b0;
          end
        end
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase

    // Registered outputs describe the cycle after this edge, so the chain
    // sees head and gate together one cycle after a word is taken.
    ccff_shift_en_d = (state_d == LOAD) && shreg_vld_d;
    ccff_head_d     = ccff_shift_en_d ? shreg_d[0] : ccff_head_q;
    busy_d          = (state_d == LOAD);
    done_d          = (state_d == DONE);
  end

  always_ff @(posedge prog_clk or negedge prog_rst_n) begin
    if (!prog_rst_n) begin
      state_q         <= IDLE;
      shreg_q         <= '0;
      shreg_vld_q     <= 1'b0;
      bits_left_q     <= '0;
      word_cnt_q      <= '0;
      bit_count_q     <= '0;
      ccff_head_q     <= 1'b0;
      ccff_shift_en_q <= 1'b0;
      busy_q          <= 1'b0;
      done_q          <= 1'b0;
      aborted_q       <= 1'b0;
    end else begin
      state_q         <= state_d;
      shreg_q         <= shreg_d;
      shreg_vld_q     <= shreg_vld_d;
      bits_left_q     <= bits_left_d;
      word_cnt_q      <= word_cnt_d;
      bit_count_q     <= bit_count_d;
      ccff_head_q     <= ccff_head_d;
      ccff_shift_en_q <= ccff_shift_en_d;
      busy_q          <= busy_d;
      done_q          <= done_d;
      aborted_q       <= aborted_d;
    end
  end

  // Tail bit is captured on the same edges the chain advances.
  ccff_crc16_serial u_crc (
    .clk    (prog_clk),
    .rst_n  (prog_rst_n),
    .clr    (start_go),
    .en     (shift),
    .bit_in (ccff_tail),
    .crc    (readback_crc)
  );

  assign ccff_head     = ccff_head_q;
  assign ccff_shift_en = ccff_shift_en_q;
  assign busy          = busy_q;
  assign done          = done_q;
  assign aborted       = aborted_q;
  assign bit_count     = bit_count_q;

endmodule

// File: tb/tb_ccff_bitstream_loader.sv
module tb_ccff_bitstream_loader;

  logic        prog_clk = 1'b0;
  logic        prog_rst_n;
  logic        start, abort, cfg_valid, cfg_ready;
  logic [7:0]  cfg_data;
  logic        ccff_head, ccff_shift_en, ccff_tail;
  logic        busy, done, aborted;
  logic [15:0] bit_count, readback_crc;

  // second instance: single-word chain
  logic        start_b, abort_b, cfg_valid_b, cfg_ready_b;
  logic [7:0]  cfg_data_b;
  logic        ccff_head_b, ccff_shift_en_b, ccff_tail_b;
  logic        busy_b, done_b, aborted_b;
  logic [15:0] bit_count_b, readback_crc_b;

  always #5 prog_clk = ~prog_clk;

  ccff_bitstream_loader #(.CHAIN_LEN(36), .WORD_W(8)) dut (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start), .abort(abort),
    .cfg_data(cfg_data), .cfg_valid(cfg_valid), .cfg_ready(cfg_ready),
    .ccff_head(ccff_head), .ccff_shift_en(ccff_shift_en), .ccff_tail(ccff_tail),
    .busy(busy), .done(done), .aborted(aborted), .bit_count(bit_count),
    .readback_crc(readback_crc)
  );

  ccff_bitstream_loader #(.CHAIN_LEN(8), .WORD_W(8)) dut_b (
    .prog_clk(prog_clk), .prog_rst_n(prog_rst_n), .start(start_b), .abort(abort_b),
    .cfg_data(cfg_data_b), .cfg_valid(cfg_valid_b), .cfg_ready(cfg_ready_b),
    .ccff_head(ccff_head_b), .ccff_shift_en(ccff_shift_en_b), .ccff_tail(ccff_tail_b),
    .busy(busy_b), .done(done_b), .aborted(aborted_b), .bit_count(bit_count_b),
    .readback_crc(readback_crc_b)
  );

  // chain model: chain[0] is the head flop, chain[35] drives the tail
  logic [35:0] chain;
  logic        chain_clr;
  always @(posedge prog_clk)
    if (chain_clr)          chain <= '0;
    else if (ccff_shift_en) chain <= {chain[34:0], ccff_head};
  assign ccff_tail = chain[35];

  int n_assert = 0;
  int n_fail   = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // scoreboard of head bits, pushed when a word is handed over
  logic q[$];
  bit   sb_en = 1'b1;
  always @(negedge prog_clk)
    if (sb_en && prog_rst_n && ccff_shift_en) begin
      chk("sb_queue_has_bit", (q.size() > 0), 1'b1);
      if (q.size() > 0) chk("sb_head", ccff_head, q.pop_front());
    end

  int done_cnt = 0;
  always @(negedge prog_clk) if (done) done_cnt++;

  logic [7:0]  words [5];
  logic [35:0] exp_ch;
  logic [35:0] ld_snap;
  int          ld_shifts, ld_first, ld_last, ld_dc0;

  // golden CRC over tail bits: tail sequence is snap[35], snap[34], ...
  function automatic logic [15:0] crc_model(input logic [35:0] snap);
    logic [15:0] c;
    logic        fb;
    c = 16'hFFFF;
    for (int k = 0; k < 36; k++) begin
      fb = c[15] ^ snap[35-k];
      c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    end
    return c;
  endfunction

  task automatic run_load(input int gap, input int abort_at);
    int   wi, g, nb;
    logic acc;
    bit   fin;
    logic [7:0] w;
    wi = 0; g = 0; fin = 0; ld_shifts = 0; ld_first = -1; ld_last = -1;
    ld_snap = chain; ld_dc0 = done_cnt; q.delete();
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    chk("start_busy", busy, 1'b1);
    chk("start_bit_count", bit_count, 16'd0);
    for (int c = 0; c < 400 && !fin; c++) begin
      if (abort_at > 0 && ld_shifts == abort_at) begin
        abort = 1'b1; cfg_valid = 1'b0;
        @(posedge prog_clk); #1;
        abort = 1'b0; fin = 1;
      end else if (done) begin
        fin = 1;
      end else begin
        if (ccff_shift_en) begin
          if (ld_first < 0) ld_first = c;
          ld_last = c; ld_shifts++;
        end
        if (wi < 5 && g == 0) begin cfg_data = words[wi]; cfg_valid = 1'b1; end
        else cfg_valid = 1'b0;
        if (cfg_ready && g > 0) g--;
        acc = cfg_valid && cfg_ready;
        @(posedge prog_clk); #1;
        if (acc) begin
          w  = words[wi];
          nb = (wi == 4) ? 4 : 8;
          for (int b = 0; b < nb; b++) q.push_back(w[b]);
          wi++; g = gap;
        end
      end
    end
    cfg_valid = 1'b0;
    chk("load_finished_in_budget", fin, 1'b1);
  endtask

  task automatic check_full(input int span);
    chk("done_pulse", done, 1'b1);
    chk("bit_count_36", bit_count, 16'd36);
    chk("busy_low_in_done", busy, 1'b0);
    chk("shift_count", ld_shifts, 36);
    chk("shift_span", ld_last - ld_first + 1, span);
    chk("chain_contents", chain, exp_ch);
    chk("readback_crc", readback_crc, crc_model(ld_snap));
    chk("sb_drained", q.size(), 0);
    @(posedge prog_clk); #1;
    chk("done_one_cycle", done, 1'b0);
    chk("done_count", done_cnt - ld_dc0, 1);
    chk("crc_holds", readback_crc, crc_model(ld_snap));
    chk("no_ready_after", cfg_ready, 1'b0);
  endtask

  int          acc_b, sh_b, last_b, dcyc_b;
  logic [7:0]  bits_b;
  logic [15:0] crc_before;

  initial begin
    words[0] = 8'hA5; words[1] = 8'h3C; words[2] = 8'hFF; words[3] = 8'h00; words[4] = 8'h0F;
    for (int k = 0; k < 36; k++) exp_ch[35-k] = words[k/8][k%8];

    prog_rst_n = 1'b0; start = 0; abort = 0; cfg_valid = 0; cfg_data = '0; chain_clr = 1'b1;
    start_b = 0; abort_b = 0; cfg_valid_b = 0; cfg_data_b = '0; ccff_tail_b = 1'b0;
    repeat (2) @(posedge prog_clk);
    #1;
    chk("rst_cfg_ready", cfg_ready, 1'b0);
    chk("rst_head", ccff_head, 1'b0);
    chk("rst_shift_en", ccff_shift_en, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_done", done, 1'b0);
    chk("rst_aborted", aborted, 1'b0);
    chk("rst_bit_count", bit_count, 16'd0);
    chk("rst_crc", readback_crc, 16'hFFFF);
    prog_rst_n = 1'b1;
    @(posedge prog_clk); #1;
    chain_clr = 1'b0;

    // 1: streaming load, valid held high, no bubbles
    run_load(0, 0);
    check_full(36);

    // 2+3a: gapped load over the scenario-1 pattern, three bubbles per gap
    chk("preload_is_pattern", chain, exp_ch);
    run_load(3, 0);
    check_full(48);

    // 3b: all-zero preload
    chain_clr = 1'b1;
    @(posedge prog_clk); #1;
    chain_clr = 1'b0;
    run_load(0, 0);
    chk("zero_preload_crc", readback_crc, crc_model(36'h0));
    check_full(36);

    // 4: abort in the cycle after the 20th shift
    run_load(0, 20);
    q.delete();
    chk("abort_pulse", aborted, 1'b1);
    chk("abort_busy", busy, 1'b0);
    chk("abort_bit_count", bit_count, 16'd20);
    chk("abort_no_done", done, 1'b0);
    chk("abort_no_ready", cfg_ready, 1'b0);
    @(posedge prog_clk); #1;
    chk("abort_one_cycle", aborted, 1'b0);
    chk("abort_bit_count_hold", bit_count, 16'd20);
    chk("abort_no_shift", ccff_shift_en, 1'b0);
    chk("abort_ready_low", cfg_ready, 1'b0);
    chk("abort_done_count", done_cnt - ld_dc0, 0);
    run_load(0, 0);
    check_full(36);

    // 5: start while busy is ignored; reset mid-load
    sb_en = 1'b0;
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0; cfg_data = 8'hA5; cfg_valid = 1'b1;
    @(posedge prog_clk); #1;
    cfg_valid = 1'b0;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("mid_bit_count", bit_count, 16'd3);
    start = 1'b1;
    @(posedge prog_clk); #1;
    start = 1'b0;
    chk("start_ignored_bit_count", bit_count, 16'd4);
    chk("start_ignored_busy", busy, 1'b1);
    prog_rst_n = 1'b0;
    #1;
    chk("mid_rst_cfg_ready", cfg_ready, 1'b0);
    chk("mid_rst_head", ccff_head, 1'b0);
    chk("mid_rst_shift_en", ccff_shift_en, 1'b0);
    chk("mid_rst_busy", busy, 1'b0);
    chk("mid_rst_done", done, 1'b0);
    chk("mid_rst_aborted", aborted, 1'b0);
    chk("mid_rst_bit_count", bit_count, 16'd0);
    chk("mid_rst_crc", readback_crc, 16'hFFFF);
    repeat (2) @(posedge prog_clk);
    #1;
    prog_rst_n = 1'b1;
    repeat (3) @(posedge prog_clk);
    #1;
    chk("post_rst_no_shift", ccff_shift_en, 1'b0);
    chk("post_rst_busy", busy, 1'b0);
    chk("post_rst_bit_count", bit_count, 16'd0);
    sb_en = 1'b1;

    // 6: CHAIN_LEN=8, WORD_W=8 -> one word, 8 shifts
    start_b = 1'b1;
    @(posedge prog_clk); #1;
    start_b = 1'b0; cfg_valid_b = 1'b1; cfg_data_b = 8'h5A;
    acc_b = 0; sh_b = 0; last_b = -1; dcyc_b = -1; bits_b = '0;
    for (int c = 0; c < 40 && dcyc_b < 0; c++) begin
      if (cfg_ready_b && cfg_valid_b) acc_b++;
      if (ccff_shift_en_b) begin
        if (sh_b < 8) bits_b[sh_b] = ccff_head_b;
        sh_b++; last_b = c;
      end
      if (done_b) dcyc_b = c;
      @(posedge prog_clk); #1;
      if (acc_b > 0) cfg_data_b = 8'hC3;
    end
    cfg_valid_b = 1'b0;
    chk("b_words_accepted", acc_b, 1);
    chk("b_shifts", sh_b, 8);
    chk("b_head_bits", bits_b, 8'h5A);
    chk("b_done_after_last", dcyc_b, last_b + 1);
    chk("b_bit_count", bit_count_b, 16'd8);
    chk("b_busy", busy_b, 1'b0);
    chk("b_no_ready", cfg_ready_b, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  // hard stop in case a wait above misbehaves
  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

endmodule
